// File: rtl/note_dispatcher_if.sv
// Bundles the song-reader stream and the player-bank outputs of the note dispatcher.
// The master modport is the song reader and sequencer side; the slave modport is the dispatcher.
interface note_dispatcher_if #(
  parameter int NUM_PLAYERS = 3
);
  logic                     play;
  logic                     beat;
  logic                     flush;
  logic                     new_note;
  logic [5:0]               note;
  logic [5:0]               duration;
  logic                     player_ready;
  logic [NUM_PLAYERS-1:0]   load_note;
  logic [6*NUM_PLAYERS-1:0] player_note;
  logic [NUM_PLAYERS-1:0]   player_active;
  logic                     all_idle;

  modport master (
    output play, beat, flush, new_note, note, duration,
    input  player_ready, load_note, player_note, player_active, all_idle
  );

  modport slave (
    input  play, beat, flush, new_note, note, duration,
    output player_ready, load_note, player_note, player_active, all_idle
  );
endinterface

// File: rtl/note_dispatcher.sv
// Round-robin allocator of a small note-player pool with per-player beat countdowns,
// so that chord notes released back to back sound together.
module note_dispatcher #(
  parameter int NUM_PLAYERS = 3,
  parameter int PTR_W       = 2
) (
  input  logic            i_clk,
  input  logic            i_reset,
  note_dispatcher_if.slave bus
);

  logic [5:0]               r_cnt [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0]   r_active;
  logic [NUM_PLAYERS-1:0]   r_load;
  logic [6*NUM_PLAYERS-1:0] r_note;
  logic [PTR_W-1:0]         r_ptr;

  logic [NUM_PLAYERS-1:0]   w_free;
  logic                     w_ready;
  logic                     w_load;
  logic                     w_found;
  logic [PTR_W-1:0]         w_sel_idx;
  logic [NUM_PLAYERS-1:0]   w_sel;
  logic [PTR_W-1:0]         w_ptr_next;

  assign w_free  = ~r_active;
  assign w_ready = (|w_free) & ~bus.flush & ~i_reset;
  // Rests (note or duration of zero) are consumed without touching any player.
  assign w_load  = bus.new_note & w_ready & (bus.note != 6'd0) & (bus.duration != 6'd0);

  // Pick the first free player scanning from the round-robin pointer, with wrap.
  always_comb begin
    int v_idx;
    logic [PTR_W-1:0] v_idx_l;
    w_found   = 1'b0;
    w_sel_idx = '0;
    w_sel     = '0;
    v_idx     = 0;
    v_idx_l   = '0;
    for (int k = 0; k < NUM_PLAYERS; k++) begin
      v_idx = int'(r_ptr) + k;
      if (v_idx >= NUM_PLAYERS) begin
        v_idx = v_idx - NUM_PLAYERS;
      end else begin
        v_idx = v_idx;
      end
      v_idx_l = PTR_W'(v_idx);
      if (!w_found && w_free[v_idx_l]) begin
        w_found   = 1'b1;
        w_sel_idx = v_idx_l;
      end else begin
        w_found   = w_found;
      end
    end
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (w_load && w_found && (w_sel_idx == PTR_W'(i))) begin
        w_sel[i] = 1'b1;
      end else begin
        w_sel[i] = 1'b0;
      end
    end
    if (w_sel_idx == PTR_W'(NUM_PLAYERS - 1)) begin
      w_ptr_next = '0;
    end else begin
      w_ptr_next = w_sel_idx + PTR_W'(1);
    end
  end

  // Player state: countdowns, activity flags, held notes, load pulses and pointer.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        r_cnt[i] <= 6'd0;
      end
      r_active <= '0;
      r_load   <= '0;
      r_note   <= '0;
      r_ptr    <= '0;
    end else if (bus.flush) begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        r_cnt[i] <= 6'd0;
      end
      r_active <= '0;
      r_load   <= '0;
      r_ptr    <= '0;
    end else begin
      r_load <= w_sel;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        if (w_sel[i]) begin
          r_cnt[i]         <= bus.duration;
          r_active[i]      <= 1'b1;
          r_note[6*i +: 6] <= bus.note;
        end else if (bus.beat && bus.play && r_active[i]) begin
          r_cnt[i] <= r_cnt[i] - 6'd1;
          if (r_cnt[i] == 6'd1) begin
            r_active[i] <= 1'b0;
          end
        end
      end
      if (w_load && w_found) begin
        r_ptr <= w_ptr_next;
      end
    end
  end

  assign bus.player_ready  = w_ready;
  assign bus.load_note     = r_load;
  assign bus.player_note   = r_note;
  assign bus.player_active = r_active;
  assign bus.all_idle      = ~|r_active;

endmodule

// File: tb/tb_note_dispatcher.sv
// Randomized bench for note_dispatcher checked against a remaining-beats pool model.
module tb_note_dispatcher;
  localparam int N = 3;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  int   rem   [N];
  int   mnote [N];
  int   mptr;
  int   mload;

  note_dispatcher_if #(.NUM_PLAYERS(N)) bus ();

  note_dispatcher #(.NUM_PLAYERS(N), .PTR_W(2)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_active();
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < N; i++) v[i] = (rem[i] > 0);
    return v;
  endfunction

  function automatic logic [31:0] exp_notes();
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < N; i++) v = v | (32'(mnote[i]) << (6 * i));
    return v;
  endfunction

  function automatic bit any_free();
    bit f;
    f = 1'b0;
    for (int i = 0; i < N; i++) if (rem[i] == 0) f = 1'b1;
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      rem[i]   = 0;
      mnote[i] = 0;
    end
    mptr  = 0;
    mload = -1;
  endtask

  task automatic check_outputs(input string tag);
    chk_val({tag, ".active"}, 32'(bus.player_active), exp_active());
    chk_val({tag, ".load"},   32'(bus.load_note), (mload < 0) ? 32'd0 : (32'd1 << mload));
    chk_val({tag, ".notes"},  32'(bus.player_note), exp_notes());
    chk_val({tag, ".idle"},   32'(bus.all_idle), 32'(exp_active() == 32'd0));
  endtask

  // One clock cycle: drive at the falling edge, check ready, step the model, check after the edge.
  task automatic cycle(input bit nn, input logic [5:0] nt, input logic [5:0] dur,
                       input bit bt, input bit pl, input bit fl);
    bit exp_ready;
    int c;
    bus.new_note = nn;
    bus.note     = nt;
    bus.duration = dur;
    bus.beat     = bt;
    bus.play     = pl;
    bus.flush    = fl;
    #1;
    exp_ready = any_free() && !fl;
    chk_val("ready", 32'(bus.player_ready), 32'(exp_ready));
    if (fl) begin
      for (int i = 0; i < N; i++) rem[i] = 0;
      mptr  = 0;
      mload = -1;
    end else begin
      c = -1;
      if (nn && exp_ready) begin
        for (int k = 0; k < N; k++) begin
          if (c < 0 && rem[(mptr + k) % N] == 0) c = (mptr + k) % N;
        end
      end
      for (int i = 0; i < N; i++) if (bt && pl && rem[i] > 0) rem[i]--;
      mload = -1;
      if (c >= 0 && nt != 6'd0 && dur != 6'd0) begin
        rem[c]   = int'(dur);
        mnote[c] = int'(nt);
        mptr     = (c + 1) % N;
        mload    = c;
      end
    end
    @(posedge clk);
    #1;
    check_outputs("cyc");
    @(negedge clk);
  endtask

  initial begin
    bit rb;
    logic [5:0] rn, rd;
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    bus.new_note = 1'b0;
    bus.note = 6'd0;
    bus.duration = 6'd0;
    bus.beat = 1'b0;
    bus.play = 1'b1;
    bus.flush = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check_outputs("rst");
    chk_val("rst.ready", 32'(bus.player_ready), 32'd1);

    // Single note, then its two beats.
    cycle(1'b1, 6'd12, 6'd2, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 6'd0, 6'd0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 6'd0, 6'd0, 1'b1, 1'b1, 1'b0);
    // Chord of three, a refused fourth, then four beats.
    cycle(1'b1, 6'd10, 6'd4, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 6'd14, 6'd4, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 6'd17, 6'd4, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 6'd20, 6'd4, 1'b0, 1'b1, 1'b0);
    repeat (4) cycle(1'b0, 6'd0, 6'd0, 1'b1, 1'b1, 1'b0);
    // Rest, then a note staged while paused.
    cycle(1'b1, 6'd0, 6'd5, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 6'd33, 6'd2, 1'b0, 1'b0, 1'b0);
    repeat (5) cycle(1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 1'b0);
    repeat (2) cycle(1'b0, 6'd0, 6'd0, 1'b1, 1'b1, 1'b0);

    for (int n = 0; n < 4000; n++) begin
      rn = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
      case ($urandom_range(0, 15))
        0:       rd = 6'd0;
        1:       rd = 6'd63;
        default: rd = 6'($urandom_range(1, 5));
      endcase
      rb = ($urandom_range(0, 3) != 0);
      cycle(rb, rn, rd, ($urandom_range(0, 1) == 1), ($urandom_range(0, 7) != 0),
            ($urandom_range(0, 63) == 0));
    end

    // Asynchronous reset in the middle of a cycle with a long note sounding.
    cycle(1'b0, 6'd0, 6'd0, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 6'd40, 6'd30, 1'b0, 1'b1, 1'b0);
    bus.new_note = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs("arst");
    chk_val("arst.ready", 32'(bus.player_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cycle(1'b1, 6'd7, 6'd1, 1'b1, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
